nx_fifo_rd_stream: RTL and testbench
====================================

// Module: nx_fifo_rd_stream
// PURPOSE
//  Read-side companion for nx_fifo. Drains a show-ahead FIFO port (empty/ren/rdata) into a
//  valid/ready stream with registered outputs. A 2-entry stage (head + skid) decouples
//  fifo_ren from out_ready, so no combinational path crosses the block.
//  Sits between any nx_fifo instance and a downstream valid/ready consumer.
//  Sustains one beat per cycle.
// PARAMETERS
//  WIDTH   96   data width; must match the FIFO WIDTH
//  CNT_W   16   width of the delivered-beat counter
// PORTS
//  clk         in   1      clock; single clock domain
//  rst_n       in   1      reset; asynchronous, active-low
//  fifo_empty  in   1      FIFO empty flag
//  fifo_rdata  in   WIDTH  FIFO head data, show-ahead; valid when fifo_empty=0
//  fifo_ren    out  1      FIFO pop; head is consumed on this clk edge
//  clear       in   1      sync flush of stage and counter; caller clears the FIFO separately
//  out_valid   out  1      stream valid
//  out_ready   in   1      stream ready
//  out_data    out  WIDTH  stream data; 0 when out_valid=0
//  stg_used    out  2      stage occupancy, 0..2
//  beat_cnt    out  CNT_W  count of accepted beats (out_valid&&out_ready)
//  idle        out  1      fifo_empty && stg_used==0
// BEHAVIOUR
//  Reset (rst_n=0, async): stg_used=0, out_valid=0, out_data=0, head/skid regs=0,
//   beat_cnt=0, run=0. run is a flop set to 1 on the first clk edge after rst_n rises.
//  fifo_ren = run && !fifo_empty && !clear && (stg_used!=2). It never depends on out_ready.
//   It never asserts while fifo_empty=1, so it can never cause FIFO underflow.
//  push = fifo_ren; pop = out_valid && out_ready; out_valid = (stg_used!=0), registered.
//  Stage state machine (stg_used), evaluated when clear=0:
//   EMPTY(0): push -> ONE, head<=fifo_rdata.
//   ONE(1):   push & !pop -> TWO, skid<=fifo_rdata.
//             push & pop  -> ONE, head<=fifo_rdata.
//             !push & pop -> EMPTY, head<=0.
//   TWO(2):   push is impossible.
//             pop -> ONE, head<=skid, skid<=0.
//             no pop -> hold.
//  Ordering: beats leave in exact FIFO pop order; the skid entry is always younger than head.
//  Stability: while out_valid=1 and out_ready=0, out_data and out_valid are held unchanged.
//  Latency: fifo_empty falling (with stg_used<2) -> fifo_ren in the same cycle ->
//   out_valid=1 in the next cycle, so 1 cycle.
//  Throughput: with out_ready=1 the stage stays at ONE and delivers one beat per cycle.
//  Backpressure: with out_ready=0 the block pops at most 2 entries, then fifo_ren=0.
//  clear: highest priority over push/pop.
//   Next state: stg_used=0, head=skid=0, beat_cnt=0, out_valid=0.
//   fifo_ren=0 during the clear cycle; a beat accepted in that cycle is not counted.
//  beat_cnt: +1 per pop; wraps from 2^CNT_W-1 to 0 silently.
//  Reset mid-operation: all state returns to reset values immediately.
//   fifo_ren stays 0 until run=1.
//  Assertions (sim only):
//   - fifo_ren implies !fifo_empty.
//   - stg_used never reaches 3.
//   - out_data stable while valid&&!ready.
// TESTING
//  1 rst_n=0 with fifo_empty=0 -> fifo_ren=0 in reset and in the first cycle after release;
//    out_valid=0, out_data=0.
//  2 FIFO holds A,B,C, out_ready=1 -> fifo_ren high 3 cycles;
//    out_data=A,B,C on consecutive cycles starting 1 cycle after the first ren; beat_cnt=3.
//  3 FIFO holds A..D, out_ready=0 -> exactly 2 ren pulses, stg_used=2, out_data=A held,
//    FIFO keeps C,D; then out_ready=1 -> A,B,C,D back-to-back, idle=1 afterwards.
//  4 stg_used=2 and clear=1 for one cycle -> fifo_ren=0 in that cycle;
//    next cycle out_valid=0, stg_used=0, beat_cnt=0.
//  5 CNT_W=4, 17 accepted beats -> beat_cnt=1 (wrap).
//  6 Random fifo_empty and out_ready over 10k cycles with a scoreboard ->
//    in-order, lossless, no duplicates, no assertion fires.

Source files
------------

// File: rtl/nx_fifo_rd_stream.sv
// Read-side companion for nx_fifo: drains a show-ahead FIFO port into a registered
// valid/ready stream through a two-entry head/skid stage.
module nx_fifo_rd_stream #(
    parameter int WIDTH = 96,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_ren,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       stg_used,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             idle
);

    logic             run_r;
    logic [1:0]       stg_used_r;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] skid_r;
    logic             out_valid_r;
    logic [CNT_W-1:0] beat_cnt_r;
    logic             push_s;
    logic             pop_s;

    // Pop decision looks only at local state, never at out_ready.
    assign fifo_ren  = run_r && !fifo_empty && !clear && (stg_used_r != 2'd2);
    assign push_s    = fifo_ren;
    assign pop_s     = out_valid_r && out_ready;

    assign out_valid = out_valid_r;
    assign out_data  = head_r;
    assign stg_used  = stg_used_r;
    assign beat_cnt  = beat_cnt_r;
    assign idle      = fifo_empty && (stg_used_r == 2'd0);

    // Run flag: holds off FIFO reads until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // Stage state machine; head is zeroed whenever it empties so out_data reads 0 when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_used_r  <= 2'd0;
            head_r      <= {WIDTH{1'b0}};
            skid_r      <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else if (clear) begin
            stg_used_r  <= 2'd0;
            head_r      <= {WIDTH{1'b0}};
            skid_r      <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            case (stg_used_r)
                2'd0: begin
                    if (push_s) begin
                        stg_used_r  <= 2'd1;
                        head_r      <= fifo_rdata;
                        out_valid_r <= 1'b1;
                    end
                end
                2'd1: begin
                    if (push_s && !pop_s) begin
                        stg_used_r <= 2'd2;
                        skid_r     <= fifo_rdata;
                    end else if (push_s && pop_s) begin
                        head_r <= fifo_rdata;
                    end else if (pop_s) begin
                        stg_used_r  <= 2'd0;
                        head_r      <= {WIDTH{1'b0}};
                        out_valid_r <= 1'b0;
                    end
                end
                2'd2: begin
                    if (pop_s) begin
                        stg_used_r <= 2'd1;
                        head_r     <= skid_r;
                        skid_r     <= {WIDTH{1'b0}};
                    end
                end
                default: begin
                    stg_used_r  <= 2'd0;
                    head_r      <= {WIDTH{1'b0}};
                    skid_r      <= {WIDTH{1'b0}};
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Accepted-beat counter; wraps silently, and a beat taken during clear is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            beat_cnt_r <= {CNT_W{1'b0}};
        end else if (pop_s) begin
            beat_cnt_r <= beat_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    nx_fifo_rd_stream_chk #(.WIDTH(WIDTH)) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_ren   (fifo_ren),
        .clear      (clear),
        .out_valid  (out_valid_r),
        .out_ready  (out_ready),
        .out_data   (head_r),
        .stg_used   (stg_used_r)
    );

endmodule

// Simulation-time protocol checks for the stream stage.
module nx_fifo_rd_stream_chk #(
    parameter int WIDTH = 96
) (
    input logic             clk,
    input logic             rst_n,
    input logic             fifo_empty,
    input logic             fifo_ren,
    input logic             clear,
    input logic             out_valid,
    input logic             out_ready,
    input logic [WIDTH-1:0] out_data,
    input logic [1:0]       stg_used
);

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_ren |-> !fifo_empty);

    a_stg_range: assert property (@(posedge clk) disable iff (!rst_n)
        stg_used != 2'd3);

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !clear) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_nx_fifo_rd_stream.sv
// Randomised bench for nx_fifo_rd_stream against a queue-based stage/FIFO model.
module tb_nx_fifo_rd_stream;

    localparam int W  = 96;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          fifo_empty;
    logic [W-1:0]  fifo_rdata;
    logic          fifo_ren;
    logic          clear;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    stg_used;
    logic [CW-1:0] beat_cnt;
    logic          idle;

    int n_checks = 0;
    int n_errors = 0;
    int ren_pulses = 0;

    logic [W-1:0] fq[$];
    logic [W-1:0] m_stage[$];
    bit           m_run = 1'b0;
    int           m_cnt = 0;

    nx_fifo_rd_stream #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_ren   (fifo_ren),
        .clear      (clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .stg_used   (stg_used),
        .beat_cnt   (beat_cnt),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic load(input int n);
        for (int i = 0; i < n; i++) fq.push_back(rand_word());
    endtask

    // One clock cycle: drive, compare against the model, advance the model over the edge.
    task automatic cycle(input logic rst, input logic clr, input logic rdy, input logic hold);
        logic         emp;
        logic         exp_ren;
        logic         exp_valid;
        logic [W-1:0] exp_data;
        logic [W-1:0] front;
        emp        = hold || (fq.size() == 0);
        front      = emp ? {W{1'b0}} : fq[0];
        rst_n      = rst;
        clear      = clr;
        out_ready  = rdy;
        fifo_empty = emp;
        fifo_rdata = emp ? rand_word() : front;
        if (!rst) begin
            m_stage.delete();
            m_run = 1'b0;
            m_cnt = 0;
        end
        #1;
        exp_ren   = m_run && !emp && !clr && (m_stage.size() < 2);
        exp_valid = (m_stage.size() != 0);
        exp_data  = exp_valid ? m_stage[0] : {W{1'b0}};
        check_eq("fifo_ren",  {127'd0, fifo_ren},  {127'd0, exp_ren});
        check_eq("out_valid", {127'd0, out_valid}, {127'd0, exp_valid});
        check_eq("out_data",  {32'd0, out_data},   {32'd0, exp_data});
        check_eq("stg_used",  {126'd0, stg_used},  128'(m_stage.size()));
        check_eq("beat_cnt",  {124'd0, beat_cnt},  128'(m_cnt));
        check_eq("idle",      {127'd0, idle},      {127'd0, (emp && m_stage.size() == 0)});
        if (fifo_ren) ren_pulses++;
        if (fifo_ren && !emp) void'(fq.pop_front());
        if (rst) begin
            if (clr) begin
                m_stage.delete();
                m_cnt = 0;
            end else begin
                if (exp_valid && rdy) begin
                    void'(m_stage.pop_front());
                    m_cnt = (m_cnt + 1) % (1 << CW);
                end
                if (exp_ren) m_stage.push_back(front);
            end
            m_run = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0;
        fifo_empty = 1'b1; fifo_rdata = {W{1'b0}};
        @(negedge clk);

        // Reset with a non-empty FIFO: no reads in reset nor in the first released cycle.
        load(3);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        ren_pulses = 0;
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("t1_ren_after_release", 128'(ren_pulses), 128'd0);

        // Three beats streamed with out_ready high.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("t2_beat_cnt", {124'd0, beat_cnt}, 128'd3);

        // Backpressure: only two pops, then drain four beats back-to-back.
        load(4);
        ren_pulses = 0;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t3_ren_pulses", 128'(ren_pulses), 128'd2);
        check_eq("t3_stg_used", {126'd0, stg_used}, 128'd2);
        check_eq("t3_fifo_left", 128'(fq.size()), 128'd2);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("t3_idle", {127'd0, idle}, 128'd1);

        // Clear with a full stage.
        load(3);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t4_full", {126'd0, stg_used}, 128'd2);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("t4_valid", {127'd0, out_valid}, 128'd0);
        check_eq("t4_stg", {126'd0, stg_used}, 128'd0);
        check_eq("t4_cnt", {124'd0, beat_cnt}, 128'd0);

        // Counter wrap: 17 accepted beats on a 4-bit counter.
        load(16);
        for (int i = 0; i < 22; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("t5_wrap", {124'd0, beat_cnt}, 128'd1);

        // Random traffic, occasional clear and mid-run reset.
        for (int i = 0; i < 10000; i++) begin
            int rdy_pct;
            rdy_pct = ((i / 500) % 3 == 0) ? 90 : (((i / 500) % 3 == 1) ? 50 : 15);
            if (fq.size() < 8 && $urandom_range(0, 1) == 1) load(1);
            cycle($urandom_range(0, 1999) != 0,
                  $urandom_range(0, 499) == 0,
                  $urandom_range(0, 99) < rdy_pct,
                  $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
